// File: rtl/axi_arb_pkg.sv
// Shared types and client identifiers for the two-client AXI read arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  localparam int   NUM_CLIENTS   = 2;
  localparam logic CLIENT_ICACHE = 1'b0;
  localparam logic CLIENT_DCACHE = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way combinational arbiter: round-robin on ties, or dcache-wins when fixed_priority is set.
module rr_arbiter_2
  import axi_arb_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   last_grant,
  input  logic                   fixed_priority,
  output logic [NUM_CLIENTS-1:0] grant
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (fixed_priority || last_grant == CLIENT_ICACHE) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read controller between icache (client 0) and dcache (client 1),
// with a saturating watchdog that force-completes a hung read with an error.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT        = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] c0_addr_i,
  output logic                  c0_busy_o,
  output logic                  c0_rvalid_o,
  output logic                  c0_rerr_o,
  output logic [DATA_WIDTH-1:0] c0_data_o,
  input  logic [ADDR_WIDTH-1:0] c1_addr_i,
  output logic                  c1_busy_o,
  output logic                  c1_rvalid_o,
  output logic                  c1_rerr_o,
  output logic [DATA_WIDTH-1:0] c1_data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_busy_i
);

  // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
  localparam int              WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  arb_state_e            state_q, state_d;
  logic                  owner_q, last_grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WD_W-1:0]       wd_q, wd_inc;
  logic [1:0]            req, grant;
  logic                  done_ok, done_to, done;

  assign req = {c1_addr_i != '0, c0_addr_i != '0};

  rr_arbiter_2 u_arb (
    .req            (req),
    .last_grant     (last_grant_q),
    .fixed_priority (FIXED_PRIORITY != 0),
    .grant          (grant)
  );

  assign wd_inc = (wd_q == '1) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d = state_q;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      IDLE:  if (|req) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!mem_busy_i) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT != 0 && wd_inc == WD_LIMIT) begin
          done_to = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = done_ok | done_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= CLIENT_ICACHE;
      last_grant_q <= CLIENT_DCACHE;
      addr_q       <= '0;
      wd_q         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (state_q == IDLE && |req) begin
        owner_q      <= grant[1];
        last_grant_q <= grant[1];
        addr_q       <= grant[1] ? c1_addr_i : c0_addr_i;
      end else if (done) begin
        addr_q <= '0;
      end
      wd_q <= (state_q == WAIT && !done) ? wd_inc : '0;
    end
  end

  assign mem_req_o  = (state_q == ISSUE);
  assign mem_addr_o = addr_q;

  // Response demux: only the owner ever sees rvalid/rerr/data.
  assign c0_rvalid_o = done    && (owner_q == CLIENT_ICACHE);
  assign c1_rvalid_o = done    && (owner_q == CLIENT_DCACHE);
  assign c0_rerr_o   = done_to && (owner_q == CLIENT_ICACHE);
  assign c1_rerr_o   = done_to && (owner_q == CLIENT_DCACHE);
  assign c0_data_o   = (done_ok && owner_q == CLIENT_ICACHE) ? mem_data_i : '0;
  assign c1_data_o   = (done_ok && owner_q == CLIENT_DCACHE) ? mem_data_i : '0;

  assign c0_busy_o = ((c0_addr_i != '0) || (owner_q == CLIENT_ICACHE && state_q != IDLE)) && !c0_rvalid_o;
  assign c1_busy_o = ((c1_addr_i != '0) || (owner_q == CLIENT_DCACHE && state_q != IDLE)) && !c1_rvalid_o;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: round-robin/TIMEOUT=8 instance plus a fixed-priority instance.
module tb_axi_read_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] c0_addr = '0, c1_addr = '0, mem_data = '0;
  logic        mem_busy = 1'b1;
  logic        c0_busy, c0_rvalid, c0_rerr, c1_busy, c1_rvalid, c1_rerr, mem_req;
  logic [31:0] c0_data, c1_data, mem_addr;

  logic [31:0] f_c0_addr = '0, f_c1_addr = '0, f_mem_data = 32'hF1F1_0000;
  logic        f_mem_busy = 1'b0;
  logic        f_c0_busy, f_c0_rvalid, f_c0_rerr, f_c1_busy, f_c1_rvalid, f_c1_rerr, f_mem_req;
  logic [31:0] f_c0_data, f_c1_data, f_mem_addr;

  int total = 0;
  int bad   = 0;
  int req_seen = 0;

  typedef struct {
    bit          client;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  logic [31:0] req_q[$];
  rsp_t        rsp_q[$];

  axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_addr_i(c0_addr), .c0_busy_o(c0_busy), .c0_rvalid_o(c0_rvalid), .c0_rerr_o(c0_rerr), .c0_data_o(c0_data),
    .c1_addr_i(c1_addr), .c1_busy_o(c1_busy), .c1_rvalid_o(c1_rvalid), .c1_rerr_o(c1_rerr), .c1_data_o(c1_data),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_data_i(mem_data), .mem_busy_i(mem_busy)
  );

  axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1), .TIMEOUT(256)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .c0_addr_i(f_c0_addr), .c0_busy_o(f_c0_busy), .c0_rvalid_o(f_c0_rvalid), .c0_rerr_o(f_c0_rerr), .c0_data_o(f_c0_data),
    .c1_addr_i(f_c1_addr), .c1_busy_o(f_c1_busy), .c1_rvalid_o(f_c1_rvalid), .c1_rerr_o(f_c1_rerr), .c1_data_o(f_c1_data),
    .mem_req_o(f_mem_req), .mem_addr_o(f_mem_addr), .mem_data_i(f_mem_data), .mem_busy_i(f_mem_busy)
  );

  // Scoreboard monitor: address checked on every mem_req pulse, response on every rvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [1:0]  rv, re;
      logic [31:0] rd [2];
      rv = {c1_rvalid, c0_rvalid};
      re = {c1_rerr, c0_rerr};
      rd[0] = c0_data;
      rd[1] = c1_data;
      if (mem_req) begin
        req_seen++;
        total++;
        if (req_q.size() == 0) begin
          bad++;
          $display("FAIL sb_req: unexpected mem_req addr=%h", mem_addr);
        end else begin
          logic [31:0] ea;
          ea = req_q.pop_front();
          if (mem_addr !== ea) begin
            bad++;
            $display("FAIL sb_addr: got %h want %h", mem_addr, ea);
          end
        end
      end
      total++;
      if (rv == 2'b11) begin
        bad++;
        $display("FAIL sb_both_rvalid: both clients got rvalid");
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rv[k]) begin
          if (rsp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_rsp: unexpected rvalid on c%0d", k);
          end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            if (e.client !== 1'(k) || rd[k] !== e.data || re[k] !== e.err) begin
              bad++;
              $display("FAIL sb_rsp: c%0d data=%h err=%b want c%0d data=%h err=%b",
                       k, rd[k], re[k], e.client, e.data, e.err);
            end
          end
        end else if (rd[k] !== '0 || re[k] !== 1'b0) begin
          bad++;
          $display("FAIL sb_idle_out: c%0d data=%h err=%b want 0 0", k, rd[k], re[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (mem_req) ok = 1'b1;
      else tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_req: mem_req not seen within 40 cycles, got 0 want 1");
    end
  endtask

  // Memory model: n busy WAIT cycles, then one cycle of valid data.
  task automatic serve(input int n, input logic [31:0] d);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    repeat (n + 1) tick();
    mem_busy = 1'b0;
    mem_data = d;
    tick();
    mem_busy = 1'b1;
    mem_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({c0_busy, c0_rvalid, c0_rerr, c0_data, c1_busy, c1_rvalid, c1_rerr, c1_data, mem_req, mem_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: c0=%b%b%b %h c1=%b%b%b %h req=%b addr=%h want all 0",
               c0_busy, c0_rvalid, c0_rerr, c0_data, c1_busy, c1_rvalid, c1_rerr, c1_data, mem_req, mem_addr);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    c0_addr = 32'h1C00_0000;
    req_q.push_back(32'h1C00_0000);
    rsp_q.push_back('{client: 1'b0, data: 32'hDEAD_BEEF, err: 1'b0});
    wait_req(ok);
    total++;
    if (mem_addr !== 32'h1C00_0000) begin
      bad++;
      $display("FAIL single_addr: got %h want 1c000000", mem_addr);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (c0_rvalid !== 1'b0 || c0_busy !== 1'b1) begin
        bad++;
        $display("FAIL single_wait%0d: rvalid=%b busy=%b want 0 1", i, c0_rvalid, c0_busy);
      end
    end
    tick();
    mem_busy = 1'b0;
    mem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (c0_rvalid !== 1'b1 || c0_data !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL single_rsp: rvalid=%b data=%h want 1 deadbeef", c0_rvalid, c0_data);
    end
    total++;
    if ({c1_busy, c1_rvalid, c1_rerr, c1_data} !== '0) begin
      bad++;
      $display("FAIL single_c1_quiet: c1=%b%b%b %h want all 0", c1_busy, c1_rvalid, c1_rerr, c1_data);
    end
    tick();
    mem_busy = 1'b1;
    mem_data = '0;
    c0_addr  = '0;
    #1;
    total++;
    if (mem_addr !== '0 || c0_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: addr=%h busy=%b want 0 0", mem_addr, c0_busy);
    end
  endtask

  task automatic test_latency();
    mem_busy = 1'b0;
    mem_data = 32'hA5A5_0001;
    req_q.push_back(32'h0000_4000);
    rsp_q.push_back('{client: 1'b0, data: 32'hA5A5_0001, err: 1'b0});
    c0_addr = 32'h0000_4000;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || c0_busy !== 1'b1) begin
      bad++;
      $display("FAIL lat_n: req=%b busy=%b want 0 1", mem_req, c0_busy);
    end
    tick();
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || c0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL lat_n1: req=%b rvalid=%b want 1 0", mem_req, c0_rvalid);
    end
    tick();
    @(negedge clk);
    total++;
    if (c0_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL lat_n2: rvalid=%b want 1", c0_rvalid);
    end
    tick();
    c0_addr  = '0;
    mem_busy = 1'b1;
    mem_data = '0;
  endtask

  task automatic test_drop();
    bit ok;
    int req_base;
    req_base = req_seen;
    c1_addr = 32'h3000_0040;
    req_q.push_back(32'h3000_0040);
    rsp_q.push_back('{client: 1'b1, data: 32'hCAFE_F00D, err: 1'b0});
    wait_req(ok);
    tick();
    c1_addr = '0;
    @(negedge clk);
    total++;
    if (c1_busy !== 1'b1) begin
      bad++;
      $display("FAIL drop_busy_inflight: got %b want 1", c1_busy);
    end
    tick();
    tick();
    mem_busy = 1'b0;
    mem_data = 32'hCAFE_F00D;
    @(negedge clk);
    total++;
    if (c1_rvalid !== 1'b1 || c1_busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_rsp: rvalid=%b busy=%b want 1 0", c1_rvalid, c1_busy);
    end
    tick();
    mem_busy = 1'b1;
    mem_data = '0;
    repeat (4) tick();
    total++;
    if (req_seen - req_base !== 1 || c1_busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_one_req: reqs=%0d busy=%b want 1 0", req_seen - req_base, c1_busy);
    end
  endtask

  // Previous grant went to c1, so round-robin must start with c0.
  task automatic test_round_robin();
    logic [31:0] d [4] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
    for (int i = 0; i < 4; i++) begin
      req_q.push_back((i % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000);
      rsp_q.push_back('{client: 1'(i % 2), data: d[i], err: 1'b0});
    end
    c0_addr = 32'h1000_0000;
    c1_addr = 32'h2000_0000;
    for (int i = 0; i < 4; i++) serve(0, d[i]);
    c0_addr = '0;
    c1_addr = '0;
    repeat (3) tick();
    total++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL rr_drain: req_q=%0d rsp_q=%0d want 0 0", req_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    mem_busy = 1'b1;
    mem_data = 32'hFFFF_FFFF;
    c0_addr  = 32'h5000_0000;
    req_q.push_back(32'h5000_0000);
    rsp_q.push_back('{client: 1'b0, data: 32'h0, err: 1'b1});
    wait_req(ok);
    for (int i = 1; i <= 8; i++) begin
      tick();
      @(negedge clk);
      total++;
      if (c0_rvalid !== (i == 8) || c0_rerr !== (i == 8)) begin
        bad++;
        $display("FAIL to_wait%0d: rvalid=%b rerr=%b want %0d %0d", i, c0_rvalid, c0_rerr, i == 8, i == 8);
      end
    end
    total++;
    if (c0_data !== '0) begin
      bad++;
      $display("FAIL to_data: got %h want 0", c0_data);
    end
    tick();
    c0_addr  = '0;
    mem_data = '0;
    #1;
    total++;
    if (mem_addr !== '0 || c0_busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL to_idle: addr=%h busy=%b req=%b want 0 0 0", mem_addr, c0_busy, mem_req);
    end
    c0_addr = 32'h5000_0004;
    req_q.push_back(32'h5000_0004);
    rsp_q.push_back('{client: 1'b0, data: 32'h600D_600D, err: 1'b0});
    serve(1, 32'h600D_600D);
    c0_addr = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    c0_addr = 32'h7000_0000;
    req_q.push_back(32'h7000_0000);
    wait_req(ok);
    tick();
    c0_addr = '0;
    tick();
    #2 rst_n = 1'b0;
    req_q.delete();
    rsp_q.delete();
    #1;
    total++;
    if ({c0_busy, c0_rvalid, c0_rerr, c0_data, c1_busy, c1_rvalid, c1_rerr, c1_data, mem_req, mem_addr} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: c0=%b%b%b c1=%b%b%b req=%b addr=%h want all 0",
               c0_busy, c0_rvalid, c0_rerr, c1_busy, c1_rvalid, c1_rerr, mem_req, mem_addr);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_busy = 1'b0;
    mem_data = 32'h0000_1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0 || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_quiet%0d: c0_rvalid=%b c1_rvalid=%b req=%b want 0 0 0", i, c0_rvalid, c1_rvalid, mem_req);
      end
    end
    tick();
    mem_busy = 1'b1;
    mem_data = '0;
  endtask

  // Fixed priority: c1 wins every tie until it drops, then c0 is served.
  task automatic test_fixed();
    f_c0_addr = 32'h8000_0000;
    f_c1_addr = 32'h9000_0000;
    for (int n = 0; n < 3; n++) begin
      bit          hit;
      bit          exp_c1;
      logic [31:0] exp_addr;
      hit = 1'b0;
      exp_c1 = (n < 2);
      exp_addr = exp_c1 ? 32'h9000_0000 : 32'h8000_0000;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(negedge clk);
        if (f_c0_rvalid || f_c1_rvalid) hit = 1'b1;
      end
      total++;
      if (!hit) begin
        bad++;
        $display("FAIL fp_timeout%0d: no rvalid within 20 cycles", n);
      end else if (f_c1_rvalid !== exp_c1 || f_c0_rvalid !== !exp_c1 || f_mem_addr !== exp_addr
                   || (exp_c1 ? f_c1_data : f_c0_data) !== 32'hF1F1_0000) begin
        bad++;
        $display("FAIL fp_grant%0d: c0=%b c1=%b addr=%h want c1=%b addr=%h", n, f_c0_rvalid, f_c1_rvalid,
                 f_mem_addr, exp_c1, exp_addr);
      end
      tick();
      if (n == 1) f_c1_addr = '0;
      if (n == 2) f_c0_addr = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_latency();
    test_drop();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_fixed();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
